// File: rtl/cp0_exc_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PRId, mfc0/mtc0 access and exception/interrupt request.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VALUE    = 32'h2021_0707,
    parameter int          TIMER_IRQ_BIT = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC_M,
    input  logic [4:0]  ExcCode,
    input  logic        BD,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic        Req,
    output logic [31:0] EPC
);

    // SR.EXL doubles as the handler-state register
    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [5:0]  im_r;
    logic        ie_r;
    logic        cause_bd_r;
    logic [5:0]  cause_ip_r;
    logic [4:0]  cause_exc_r;
    logic [31:0] epc_r;

    logic [5:0]  timer_ip_s;
    logic [5:0]  ip_eff_s;
    logic        exl_s;
    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic        wr_s;
    logic        exl_nx_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

`ifdef CP0_TIMER_EN
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pend_r;

    // Count/Compare timer; a Compare write always clears pending, even on a match cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            pend_r    <= 1'b0;
        end else begin
            if (wr_s && (A2 == 5'd9)) begin
                count_r <= DIn;
            end else begin
                count_r <= count_r + 32'd1;
            end
            if (wr_s && (A2 == 5'd11)) begin
                compare_r <= DIn;
                pend_r    <= 1'b0;
            end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
                pend_r <= 1'b1;
            end else begin
                pend_r <= pend_r;
            end
        end
    end

    // Route timer pending onto its interrupt line
    always_comb begin
        timer_ip_s                = 6'd0;
        timer_ip_s[TIMER_IRQ_BIT] = pend_r;
    end
`else
    assign timer_ip_s = 6'd0;
`endif

    assign exl_s     = (state_r == HANDLER);
    assign ip_eff_s  = HWInt | timer_ip_s;
    assign int_req_s = (|(im_r & ip_eff_s)) & ie_r & ~exl_s;
    assign exc_req_s = (ExcCode != 5'd0) & ~exl_s;
    assign req_s     = reset_n & (int_req_s | exc_req_s);
    assign wr_s      = WE & ~req_s;
    assign Req       = req_s;
    assign EPC       = epc_r;

    assign sr_s    = {16'd0, im_r, 8'd0, exl_s, ie_r};
    assign cause_s = {cause_bd_r, 15'd0, cause_ip_r, 3'd0, cause_exc_r, 2'b00};

    // Handler-state transitions: mtc0 to SR applies before eret clears EXL
    always_comb begin
        state_nx_s = state_r;
        exl_nx_s   = exl_s;
        if (req_s) begin
            state_nx_s = HANDLER;
        end else begin
            if (wr_s && (A2 == 5'd12)) begin
                exl_nx_s = DIn[1];
            end else begin
                exl_nx_s = exl_s;
            end
            if (EXLClr) begin
                exl_nx_s = 1'b0;
            end else begin
                exl_nx_s = exl_nx_s;
            end
            state_nx_s = exl_nx_s ? HANDLER : NORMAL;
        end
    end

    // Architectural register updates; an exception drops any same-cycle mtc0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= NORMAL;
            im_r        <= 6'd0;
            ie_r        <= 1'b0;
            cause_bd_r  <= 1'b0;
            cause_ip_r  <= 6'd0;
            cause_exc_r <= 5'd0;
            epc_r       <= 32'd0;
        end else begin
            state_r    <= state_nx_s;
            cause_ip_r <= ip_eff_s;
            if (req_s) begin
                cause_bd_r  <= BD;
                cause_exc_r <= int_req_s ? 5'd0 : ExcCode;
                epc_r       <= word_align(BD ? (PC_M - 32'd4) : PC_M);
            end else if (wr_s && (A2 == 5'd14)) begin
                epc_r <= word_align(DIn);
            end
            if (wr_s && (A2 == 5'd12)) begin
                im_r <= DIn[15:10];
                ie_r <= DIn[0];
            end
        end
    end

    // mfc0 read mux; sees pre-write values
    always_comb begin
        DOut = 32'd0;
        case (A1)
            5'd12:   DOut = sr_s;
            5'd13:   DOut = cause_s;
            5'd14:   DOut = epc_r;
            5'd15:   DOut = PRID_VALUE;
`ifdef CP0_TIMER_EN
            5'd9:    DOut = count_r;
            5'd11:   DOut = compare_r;
`endif
            default: DOut = 32'd0;
        endcase
    end

endmodule
